// File: rtl/md_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit: op codes,
// FSM states and default latencies.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Wide enough for any sensible latency parameter.
  localparam int MD_CNT_W = 16;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// Bundle between the ID/EX pipeline register / hazard unit and the mult/div unit.
interface ex_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        rd_hi;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (output start, op, src_a, src_b, rd_hi,
                  input  busy, hi, lo, md_out);
  modport slave  (input  start, op, src_a, src_b, rd_hi,
                  output busy, hi, lo, md_out);
endinterface

// File: rtl/md_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath; result packed as {hi, lo}.
import md_pkg::*;

module md_arith (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Low 64 bits of a sign-extended product equal the signed 64-bit product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes; quotient truncates toward zero, remainder follows the dividend.
  assign signed_div = (op == MD_DIV);
  assign div_a      = (signed_div && a[31]) ? (32'd0 - a) : a;
  assign div_b      = (signed_div && b[31]) ? (32'd0 - b) : b;
  assign q_mag      = (div_b == 32'd0) ? 32'd0 : div_a / div_b;
  assign r_mag      = (div_b == 32'd0) ? 32'd0 : div_a % div_b;
  assign quot       = (signed_div && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem        = (signed_div && a[31]) ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res         = 64'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV, MD_DIVU: begin
        res         = {rem, quot};
        div_by_zero = (b == 32'd0);
      end
      default: res = 64'd0;
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage multiply/divide unit: computes at accept, holds the result for
// the configured latency, then commits to HI/LO while the hazard unit stalls on busy.
import md_pkg::*;

module ex_muldiv #(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  ex_muldiv_if.slave  bus
);

  md_state_e           state, next_state;
  logic [MD_CNT_W-1:0] count, next_count;
  logic [2:0]          op_q;
  logic [63:0]         res_q;
  logic                dbz_q;
  logic [31:0]         hi_q, lo_q;

  logic [63:0]         arith_res;
  logic                arith_dbz;
  logic                accept_md, commit, wr_hi, wr_lo, commit_ok;

  md_arith u_arith (
    .op          (bus.op),
    .a           (bus.src_a),
    .b           (bus.src_b),
    .res         (arith_res),
    .div_by_zero (arith_dbz)
  );

  always_comb begin
    next_state = state;
    next_count = count;
    accept_md  = 1'b0;
    commit     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == MD_MULT || bus.op == MD_MULTU) begin
            accept_md  = 1'b1;
            next_count = MD_CNT_W'(MULT_CYCLES);
            next_state = ST_RUN;
          end else if (bus.op == MD_DIV || bus.op == MD_DIVU) begin
            accept_md  = 1'b1;
            next_count = MD_CNT_W'(DIV_CYCLES);
            next_state = ST_RUN;
          end else if (bus.op == MD_MTHI) begin
            wr_hi = 1'b1;
          end else if (bus.op == MD_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      ST_RUN: begin
        next_count = count - MD_CNT_W'(1);
        if (count == MD_CNT_W'(1)) begin
          commit     = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A divide by zero still burns its cycles but leaves HI/LO untouched.
  assign commit_ok = commit && !(dbz_q && (op_q == MD_DIV || op_q == MD_DIVU));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
      op_q  <= 3'd0;
      res_q <= 64'd0;
      dbz_q <= 1'b0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (accept_md) begin
        op_q  <= bus.op;
        res_q <= arith_res;
        dbz_q <= arith_dbz;
      end
      if (commit_ok) begin
        hi_q <= res_q[63:32];
        lo_q <= res_q[31:0];
      end else begin
        if (wr_hi) hi_q <= bus.src_a;
        if (wr_lo) lo_q <= bus.src_a;
      end
    end
  end

  assign bus.busy   = (state == ST_RUN);
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.md_out = bus.rd_hi ? hi_q : lo_q;

endmodule
